// File: rtl/tile_fetch_sequencer.sv
// rtl/tile_fetch_sequencer.sv - per-scanline sprite/background fetch and shift-enable sequencer
module tile_fetch_sequencer #(
  parameter int H_ACTIVE = 640
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [3:0]       line_row,
  input  logic [9:0]       hcount,
  input  logic             active,
  input  logic             pixel_tick,
  input  logic [7:0]       spr_valid,
  input  logic [7:0][9:0]  spr_x,
  input  logic [7:0][7:0]  spr_tile,
  input  logic [7:0][3:0]  spr_row,
  output logic             pat_rd,
  output logic [11:0]      pat_addr,
  input  logic [31:0]      pat_rdata,
  output logic             map_rd,
  output logic [5:0]       map_col,
  input  logic [7:0]       map_tile,
  output logic [8:0][31:0] load_data,
  output logic             load_sprite,
  output logic             load_background,
  output logic [8:0]       enable
);

  localparam logic [6:0] COLS     = 7'(H_ACTIVE / 16);
  localparam logic [9:0] LAST_PIX = 10'(H_ACTIVE - 1);

  typedef enum logic [3:0] {
    IDLE, SPR_FETCH, SPR_DRAIN, BG_MAP, BG_PAT, BG_CAPT, LOAD,
    RUN, PF_MAP, PF_PAT, PF_CAPT
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  idx;
  logic [2:0]  cap_idx;
  logic        cap_en;
  logic [3:0]  row_q;
  logic [7:0]  tile_q;
  logic        map_rd_q;
  logic [5:0]  col;
  logic [31:0] bg_next;
  logic        pf_done;
  logic        step;
  logic        reload_d1;
  logic        reload_q;
  logic        running;
  logic [7:0]  spr_hit;

  assign running         = (state == RUN) || (state == PF_MAP) ||
                           (state == PF_PAT) || (state == PF_CAPT);
  assign load_background = (state == LOAD) || reload_q;

  // 11-bit window compare so sprites near the right edge truncate instead of wrapping
  always_comb begin
    spr_hit = '0;
    for (int i = 0; i < 8; i++) begin
      if (spr_valid[i] &&
          ({1'b0, hcount} >= {1'b0, spr_x[i]}) &&
          ({1'b0, hcount} <= ({1'b0, spr_x[i]} + 11'd15)))
        spr_hit[i] = 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    pat_rd      = 1'b0;
    pat_addr    = '0;
    map_rd      = 1'b0;
    map_col     = '0;
    load_sprite = 1'b0;
    case (state)
      IDLE: ;
      SPR_FETCH: begin
        pat_rd   = 1'b1;
        pat_addr = {spr_tile[idx], spr_row[idx]};
        if (idx == 3'd7) state_nx = SPR_DRAIN;
      end
      SPR_DRAIN: begin
        map_rd   = 1'b1;
        state_nx = BG_MAP;
      end
      BG_MAP:  state_nx = BG_PAT;
      BG_PAT: begin
        pat_rd   = 1'b1;
        pat_addr = {tile_q, row_q};
        state_nx = BG_CAPT;
      end
      BG_CAPT: state_nx = LOAD;
      LOAD: begin
        load_sprite = 1'b1;
        state_nx    = RUN;
      end
      RUN: begin
        if (({1'b0, col} < COLS) && !pf_done) state_nx = PF_MAP;
      end
      // two cycles: issue the map read, then wait while the tile is registered
      PF_MAP: begin
        map_rd  = !step;
        map_col = col;
        if (step) state_nx = PF_PAT;
      end
      PF_PAT: begin
        pat_rd   = 1'b1;
        pat_addr = {tile_q, row_q};
        state_nx = PF_CAPT;
      end
      PF_CAPT: state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (line_start) state_nx = SPR_FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cap_idx   <= '0;
      cap_en    <= 1'b0;
      row_q     <= '0;
      tile_q    <= '0;
      map_rd_q  <= 1'b0;
      col       <= '0;
      bg_next   <= '0;
      pf_done   <= 1'b0;
      step      <= 1'b0;
      reload_d1 <= 1'b0;
      reload_q  <= 1'b0;
      load_data <= '0;
      enable    <= '0;
    end else begin
      state    <= state_nx;
      map_rd_q <= map_rd;
      step     <= (state == PF_MAP) ? ~step : 1'b0;
      cap_en   <= (state == SPR_FETCH) && !line_start;
      cap_idx  <= idx;
      idx      <= (state == SPR_FETCH && !line_start) ? idx + 3'd1 : 3'd0;
      if (line_start) row_q <= line_row;
      if (map_rd_q) tile_q <= map_tile;

      if (cap_en)
        load_data[{1'b0, cap_idx}] <= spr_valid[cap_idx] ? pat_rdata : 32'd0;
      if (state == BG_CAPT) load_data[8] <= pat_rdata;
      if (state == LOAD) col <= 6'd1;
      if (state == PF_CAPT) begin
        bg_next <= pat_rdata;
        pf_done <= 1'b1;
      end

      enable <= '0;
      if (running && pixel_tick && active) enable <= {1'b1, spr_hit};

      // reload lands two cycles after the tick so it never meets a shift enable
      reload_d1 <= running && pixel_tick && active &&
                   (hcount[3:0] == 4'hF) && (hcount < LAST_PIX);
      reload_q  <= reload_d1;
      if (reload_d1) begin
        load_data[8] <= bg_next;
        col          <= col + 6'd1;
        pf_done      <= 1'b0;
      end

      if (line_start) begin
        col       <= '0;
        pf_done   <= 1'b0;
        reload_d1 <= 1'b0;
        reload_q  <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && reload_d1) assert (pf_done);
  end

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// tb/tb_tile_fetch_sequencer.sv - scoreboard bench for tile_fetch_sequencer
module tb_tile_fetch_sequencer;
  localparam int H_ACTIVE = 640;

  logic             clk = 1'b0;
  logic             reset;
  logic             line_start;
  logic [3:0]       line_row;
  logic [9:0]       hcount;
  logic             active;
  logic             pixel_tick;
  logic [7:0]       spr_valid;
  logic [7:0][9:0]  spr_x;
  logic [7:0][7:0]  spr_tile;
  logic [7:0][3:0]  spr_row;
  logic             pat_rd;
  logic [11:0]      pat_addr;
  logic [31:0]      pat_rdata;
  logic             map_rd;
  logic [5:0]       map_col;
  logic [7:0]       map_tile;
  logic [8:0][31:0] load_data;
  logic             load_sprite;
  logic             load_background;
  logic [8:0]       enable;

  tile_fetch_sequencer #(.H_ACTIVE(H_ACTIVE)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_row(line_row),
    .hcount(hcount), .active(active), .pixel_tick(pixel_tick),
    .spr_valid(spr_valid), .spr_x(spr_x), .spr_tile(spr_tile), .spr_row(spr_row),
    .pat_rd(pat_rd), .pat_addr(pat_addr), .pat_rdata(pat_rdata),
    .map_rd(map_rd), .map_col(map_col), .map_tile(map_tile),
    .load_data(load_data), .load_sprite(load_sprite),
    .load_background(load_background), .enable(enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat_word(input logic [11:0] a);
    return {4'h5, a, 4'hC, a};
  endfunction

  // memories: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    pat_rdata <= pat_rd ? pat_word(pat_addr) : 32'hDEAD_BEEF;
    map_tile  <= map_rd ? {2'b00, map_col} : 8'hEE;
  end

  typedef struct { int cyc; logic [8:0][31:0] d; } load_t;
  typedef struct { int cyc; logic [31:0] d; } rel_t;
  typedef struct { int cyc; logic [8:0] en; } en_t;

  logic [11:0] exp_addr[$];
  logic [5:0]  exp_col[$];
  load_t       exp_load[$];
  rel_t        exp_rel[$];
  en_t         exp_en[$];

  int checks = 0;
  int errors = 0;
  bit mon_off = 1'b1;
  int cnt_load, cnt_rel, cnt_en3, cnt_en5;
  load_t le;
  rel_t  re;
  en_t   ee;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!mon_off) begin
      if (pat_rd) begin
        if (exp_addr.size() == 0) check("pat_rd_unexpected", 64'(pat_addr), 64'hFFF);
        else check("pat_addr", 64'(pat_addr), 64'(exp_addr.pop_front()));
      end
      if (map_rd) begin
        if (exp_col.size() == 0) check("map_rd_unexpected", 64'(map_col), 64'h3F);
        else check("map_col", 64'(map_col), 64'(exp_col.pop_front()));
      end
      if (load_sprite) begin
        cnt_load++;
        check("load_bg_with_spr", 64'(load_background), 64'd1);
        if (exp_load.size() == 0) check("load_unexpected", 64'(cyc), 64'd0);
        else begin
          le = exp_load.pop_front();
          check("load_cycle", 64'(cyc), 64'(le.cyc));
          for (int i = 0; i < 9; i++) check($sformatf("load_data%0d", i), 64'(load_data[i]), 64'(le.d[i]));
        end
      end else if (load_background) begin
        cnt_rel++;
        check("reload_vs_enable", 64'(enable[8]), 64'd0);
        if (exp_rel.size() == 0) check("reload_unexpected", 64'(cyc), 64'd0);
        else begin
          re = exp_rel.pop_front();
          check("reload_cycle", 64'(cyc), 64'(re.cyc));
          check("reload_data", 64'(load_data[8]), 64'(re.d));
        end
      end
      if (enable != 9'd0) begin
        if (enable[3]) cnt_en3++;
        if (enable[5]) cnt_en5++;
        if (exp_en.size() == 0) check("enable_unexpected", 64'(enable), 64'd0);
        else begin
          ee = exp_en.pop_front();
          check("enable_cycle", 64'(cyc), 64'(ee.cyc));
          check("enable", 64'(enable), 64'(ee.en));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] row, input int n_spr, input bit full);
    load_t l;
    line_row   = row;
    line_start = 1'b1;
    for (int i = 0; i < n_spr; i++) exp_addr.push_back({spr_tile[i], spr_row[i]});
    if (full) begin
      exp_addr.push_back({8'd0, row});
      exp_col.push_back(6'd0);
      for (int k = 1; k < H_ACTIVE / 16; k++) begin
        exp_col.push_back(6'(k));
        exp_addr.push_back({8'(k), row});
      end
      l.cyc = cyc + 13;
      for (int i = 0; i < 8; i++)
        l.d[i] = spr_valid[i] ? pat_word({spr_tile[i], spr_row[i]}) : 32'd0;
      l.d[8] = pat_word({8'd0, row});
      exp_load.push_back(l);
    end
    step();
    line_start = 1'b0;
  endtask

  task automatic active_span(input logic [3:0] row, input int n_pix);
    en_t  e;
    rel_t r;
    for (int h = 0; h < n_pix; h++) begin
      hcount     = 10'(h);
      active     = 1'b1;
      pixel_tick = 1'b1;
      e.cyc   = cyc + 1;
      e.en[8] = 1'b1;
      for (int i = 0; i < 8; i++)
        e.en[i] = spr_valid[i] && (h >= int'(spr_x[i])) && (h <= int'(spr_x[i]) + 15);
      exp_en.push_back(e);
      if ((h % 16 == 15) && (h < H_ACTIVE - 1)) begin
        r.cyc = cyc + 2;
        r.d   = pat_word({8'(h / 16 + 1), row});
        exp_rel.push_back(r);
      end
      step();
      pixel_tick = 1'b0;
      step();
    end
    active = 1'b0;
  endtask

  task automatic run_line(input logic [3:0] row);
    pulse(row, 8, 1'b1);
    repeat (19) step();
    active_span(row, H_ACTIVE);
    repeat (10) step();
  endtask

  task automatic clear_counts();
    cnt_load = 0; cnt_rel = 0; cnt_en3 = 0; cnt_en5 = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 64'({pat_rd, map_rd, load_sprite, load_background, enable, map_col, pat_addr}), 64'd0);
    check({tag, "_data"}, 64'(|load_data), 64'd0);
  endtask

  task automatic sprites_a();
    spr_valid = 8'b1000_0101;
    for (int i = 0; i < 8; i++) begin
      spr_tile[i] = 8'h10 + 8'(i);
      spr_row[i]  = 4'd3;
      spr_x[i]    = 10'd1023;
    end
    spr_x[0] = 10'd5;
    spr_x[2] = 10'd620;
  endtask

  task automatic sprites_b();
    spr_valid = 8'b1010_1101;
    spr_x[0]  = 10'd0;
    spr_x[2]  = 10'd300;
    spr_x[3]  = 10'd100;
    spr_x[5]  = 10'd630;
    spr_x[7]  = 10'd1023;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; line_start = 1'b0; line_row = 4'd0; hcount = '0;
    active = 1'b0; pixel_tick = 1'b0;
    sprites_a();
    step();
    for (int i = 0; i < 24; i++) begin
      line_start = (i == 2);
      active     = (i >= 6);
      pixel_tick = (i >= 6) && (i % 2 == 0);
      hcount     = 10'(i);
      step();
      check_idle_outputs("reset_outputs");
    end
    line_start = 1'b0; active = 1'b0; pixel_tick = 1'b0;
    reset = 1'b0;
    step();
    mon_off = 1'b0;

    clear_counts();
    run_line(4'd5);
    check("line1_loads", 64'(cnt_load), 64'd1);
    check("line1_reloads", 64'(cnt_rel), 64'd39);

    sprites_b();
    clear_counts();
    run_line(4'd9);
    check("spr3_enables", 64'(cnt_en3), 64'd16);
    check("spr5_enables", 64'(cnt_en5), 64'd10);
    check("line2_reloads", 64'(cnt_rel), 64'd39);

    clear_counts();
    pulse(4'd2, 5, 1'b0);
    repeat (4) step();
    run_line(4'd2);
    check("abort_loads", 64'(cnt_load), 64'd1);
    check("abort_reloads", 64'(cnt_rel), 64'd39);

    clear_counts();
    pulse(4'd7, 8, 1'b1);
    repeat (19) step();
    active_span(4'd7, 200);
    mon_off = 1'b1;
    reset   = 1'b1;
    step();
    exp_addr.delete(); exp_col.delete(); exp_load.delete();
    exp_rel.delete(); exp_en.delete();
    repeat (4) begin
      check_idle_outputs("midline_reset");
      step();
    end
    reset = 1'b0;
    step();
    mon_off = 1'b0;

    sprites_a();
    clear_counts();
    run_line(4'd11);
    check("after_reset_loads", 64'(cnt_load), 64'd1);
    check("after_reset_reloads", 64'(cnt_rel), 64'd39);

    check("addr_left", 64'(exp_addr.size()), 64'd0);
    check("col_left", 64'(exp_col.size()), 64'd0);
    check("load_left", 64'(exp_load.size()), 64'd0);
    check("reload_left", 64'(exp_rel.size()), 64'd0);
    check("enable_left", 64'(exp_en.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
